reg_hazard_scheduler: RTL and testbench
=======================================

# reg_hazard_scheduler

Dual-pipe register hazard scheduler placed between the decoder and the register controller. It keeps a per-register pending-write table and raises `shouldAStall_o` / `shouldBStall_o` when an instruction would read or overwrite a register whose earlier write has not yet written back. Entries clear on writeback, on a bounded timeout, or on flush. Pipe A is always treated as older than pipe B.

## Interface
- `NUM_REGS`, 32: registers tracked; the address width is 5 bits.
- `REG_STALL_DELAY`, 6: maximum number of cycles an entry stays busy without a writeback; legal range 1..15.
- `clock_i` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `enableA_i`, `enableB_i` in 1: the decoder presents a valid instruction on that pipe.
- `pwriteA_i`, `pwriteB_i` in 1: the instruction writes its primary register.
- `preadA_i`, `preadB_i` in 1: the instruction reads its primary register.
- `sreadA_i`, `sreadB_i` in 1: the secondary operand is a register address.
- `primOperandA_i`, `primOperandB_i` in 5: primary register address.
- `secOperandA_i`, `secOperandB_i` in 5: secondary register address, taken from the low 5 bits of the secondary operand.
- `wbA_i`, `wbB_i` in 1: writeback strobe from the execute FIFO.
- `wbAddrA_i`, `wbAddrB_i` in 5: writeback register address.
- `flushBack_i` in 1: pipeline flush.
- `shouldAStall_o`, `shouldBStall_o` out 1: combinational stall request to the decoder.
- `issueA_o`, `issueB_o` out 1: combinational accept flag, equal to enable AND NOT stall.
- `busyMask_o` out `NUM_REGS`: registered; bit r is 1 when register r has a pending write.

## Operation
- Each register has a 4-bit down-counter `cnt[r]`. The register is busy when `cnt[r] != 0`, and `busyMask_o[r]` equals `cnt[r] != 0`.
- **Hazard for pipe X** (only when `enableX_i` = 1):
  - `preadX_i` and `primOperandX_i` is busy;
  - `sreadX_i` and `secOperandX_i` is busy;
  - `pwriteX_i` and `primOperandX_i` is busy (WAW).
- **Intra-pair hazard for pipe B**, when A issues with `pwriteA_i`, B depends on A's destination if any of these holds:
  - `preadB_i` and `primOperandB_i` equals `primOperandA_i`;
  - `sreadB_i` and `secOperandB_i` equals `primOperandA_i`;
  - `pwriteB_i` and `primOperandB_i` equals `primOperandA_i`.
- **Stall equations:**
  - `shouldAStall_o` equals `enableA_i` AND hazardA.
  - `shouldBStall_o` equals `enableB_i` AND (hazardB OR intra-pair hazard OR `shouldAStall_o`). Issue is in order, so a stalled A also stalls B.
  - Both stall outputs are 0 while `flushBack_i` = 1.
- **Per-register update at each clock edge**, highest priority first:
  1. `flushBack_i` = 1: every counter is set to 0.
  2. Issue load: the counter is set to `REG_STALL_DELAY` when `issueA_o` and `pwriteA_i` target r, or when `issueB_o` and `pwriteB_i` target r.
  3. Writeback clear: the counter is set to 0 when (`wbA_i` and `wbAddrA_i` = r) or (`wbB_i` and `wbAddrB_i` = r).
  4. Otherwise, if the counter is non-zero, it decrements by 1. It saturates at 0 and never wraps.
- A writeback to a register that is not busy has no effect.
- Writebacks on both ports to the same register give a single clear.
- A flush and an issue in the same cycle: the flush wins and nothing is loaded.

## Timing
- **Reset:** while `reset_i` = 0, all counters are 0 and `busyMask_o` = 0, independent of the clock. With `enableA_i` = `enableB_i` = 0, all combinational outputs are 0.
- **Issue to busy:** an issue in cycle N makes the register busy from N+1. Same-cycle dependents are covered only by the intra-pair check.
- **Writeback to free:** a writeback in cycle N frees the register from N+1. A read of that register in cycle N still stalls; there is no writeback forwarding.
- **Timeout:** without a writeback, an issue at N keeps the register busy for cycles N+1 through N+`REG_STALL_DELAY`. It is free at N+`REG_STALL_DELAY`+1.
- **Stall latency:** stall and issue outputs respond in the same cycle as their inputs. The decoder must hold its inputs stable while stalled.
- **Reset mid-operation:** reset clears all pending state at once. Recovery needs no timeout.

## Structure
- Package `reg_sched_pkg`:
  - constants `NUM_REGS` = 32, `REG_ADDR_W` = 5, `CNT_W` = 4;
  - typedef `reg_addr_t` (5-bit);
  - typedef `busy_cnt_t` (4-bit).
- Sub-module `reg_busy_entry`:
  - holds one counter with the flush/load/clear/decrement priority;
  - inputs: `flush`, `load`, `clear`, delay value;
  - output: `busy`;
  - instantiated `NUM_REGS` times.
- The top level holds the decode of address to one-hot load/clear vectors, the hazard compare logic and the stall logic.

## Test plan
- **Reset and idle:** assert `reset_i` = 0 mid-run with registers 3 and 7 busy → `busyMask_o` = 0 immediately. After release, idle inputs give both stall outputs = 0.
- **RAW stall cleared by writeback:** A issues a write to r5 in cycle 0 → in cycle 1 A reading r5 gives `shouldAStall_o` = 1, and B also stalls. `wbA_i` to r5 in cycle 2 → A issues in cycle 3.
- **Timeout:** issue a write to r9 with no writeback → r9 busy for exactly 6 cycles, `busyMask_o[9]` = 0 on the 7th.
- **Intra-pair dependence:**
  - A writes r4 while B reads r4 in the same cycle → `issueA_o` = 1, `shouldBStall_o` = 1.
  - B reading r6 instead → both issue.
- **WAW and simultaneous events:**
  - with r2 busy, A writes r2 → A stalls.
  - an issue load and a writeback to r2 in the same cycle → the counter reloads to 6.
- **Flush:** flush with r1, r2 and r31 busy and A issuing a write to r8 → `busyMask_o` = 0 next cycle and r8 is not busy.

Source files
------------

// File: rtl/reg_sched_pkg.sv
// Shared widths and types for the register hazard scheduler.
package reg_sched_pkg;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      busy_cnt_t;
endpackage

// File: rtl/reg_busy_entry.sv
// One pending-write entry: a down-counter with flush > load > clear > decrement priority.
module reg_busy_entry
  import reg_sched_pkg::*;
(
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      flush,
  input  logic      load,
  input  logic      clear,
  input  busy_cnt_t delay,
  output logic      busy
);

  busy_cnt_t cnt_q, cnt_d;
  logic      busy_q, busy_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = delay;
    end else if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_hazard_scheduler.sv
// Dual-pipe pending-write tracker: RAW/WAW hazard detection and in-order stall generation.
module reg_hazard_scheduler
  import reg_sched_pkg::*;
#(
  parameter int unsigned REG_STALL_DELAY = 6
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enableA_i,
  input  logic                enableB_i,
  input  logic                pwriteA_i,
  input  logic                pwriteB_i,
  input  logic                preadA_i,
  input  logic                preadB_i,
  input  logic                sreadA_i,
  input  logic                sreadB_i,
  input  reg_addr_t           primOperandA_i,
  input  reg_addr_t           primOperandB_i,
  input  reg_addr_t           secOperandA_i,
  input  reg_addr_t           secOperandB_i,
  input  logic                wbA_i,
  input  logic                wbB_i,
  input  reg_addr_t           wbAddrA_i,
  input  reg_addr_t           wbAddrB_i,
  input  logic                flushBack_i,
  output logic                shouldAStall_o,
  output logic                shouldBStall_o,
  output logic                issueA_o,
  output logic                issueB_o,
  output logic [NUM_REGS-1:0] busyMask_o
);

  localparam busy_cnt_t DELAY = CNT_W'(REG_STALL_DELAY);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] load_vec;
  logic [NUM_REGS-1:0] clear_vec;
  logic hazard_a, hazard_b, intra_b;
  logic stall_a, stall_b, issue_a, issue_b;

  // Hazard and stall evaluation; flush suppresses all stalls.
  always_comb begin
    hazard_a = (preadA_i  && busy[primOperandA_i]) ||
               (sreadA_i  && busy[secOperandA_i])  ||
               (pwriteA_i && busy[primOperandA_i]);
    hazard_b = (preadB_i  && busy[primOperandB_i]) ||
               (sreadB_i  && busy[secOperandB_i])  ||
               (pwriteB_i && busy[primOperandB_i]);
    stall_a  = !flushBack_i && enableA_i && hazard_a;
    issue_a  = enableA_i && !stall_a;
    intra_b  = issue_a && pwriteA_i &&
               ((preadB_i  && (primOperandB_i == primOperandA_i)) ||
                (sreadB_i  && (secOperandB_i  == primOperandA_i)) ||
                (pwriteB_i && (primOperandB_i == primOperandA_i)));
    stall_b  = !flushBack_i && enableB_i && (hazard_b || intra_b || stall_a);
    issue_b  = enableB_i && !stall_b;
  end

  // One-hot decode of issue loads and writeback clears.
  always_comb begin
    load_vec  = '0;
    clear_vec = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      load_vec[r]  = (issue_a && pwriteA_i && (primOperandA_i == REG_ADDR_W'(r))) ||
                     (issue_b && pwriteB_i && (primOperandB_i == REG_ADDR_W'(r)));
      clear_vec[r] = (wbA_i && (wbAddrA_i == REG_ADDR_W'(r))) ||
                     (wbB_i && (wbAddrB_i == REG_ADDR_W'(r)));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    reg_busy_entry u_entry (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush   (flushBack_i),
      .load    (load_vec[g]),
      .clear   (clear_vec[g]),
      .delay   (DELAY),
      .busy    (busy[g])
    );
  end

  assign shouldAStall_o = stall_a;
  assign shouldBStall_o = stall_b;
  assign issueA_o       = issue_a;
  assign issueB_o       = issue_b;
  assign busyMask_o     = busy;

endmodule

// File: tb/tb_reg_hazard_scheduler.sv
// Directed scoreboard bench for reg_hazard_scheduler.
module tb_reg_hazard_scheduler;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_a, en_b, pw_a, pw_b, pr_a, pr_b, sr_a, sr_b;
  logic [4:0]  prim_a, prim_b, sec_a, sec_b;
  logic        wb_a, wb_b;
  logic [4:0]  wb_addr_a, wb_addr_b;
  logic        flush;
  logic        stall_a, stall_b, issue_a, issue_b;
  logic [31:0] mask;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic        is_flags;
    logic [31:0] sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  reg_hazard_scheduler #(.REG_STALL_DELAY(6)) dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .enableA_i      (en_a),
    .enableB_i      (en_b),
    .pwriteA_i      (pw_a),
    .pwriteB_i      (pw_b),
    .preadA_i       (pr_a),
    .preadB_i       (pr_b),
    .sreadA_i       (sr_a),
    .sreadB_i       (sr_b),
    .primOperandA_i (prim_a),
    .primOperandB_i (prim_b),
    .secOperandA_i  (sec_a),
    .secOperandB_i  (sec_b),
    .wbA_i          (wb_a),
    .wbB_i          (wb_b),
    .wbAddrA_i      (wb_addr_a),
    .wbAddrB_i      (wb_addr_b),
    .flushBack_i    (flush),
    .shouldAStall_o (stall_a),
    .shouldBStall_o (stall_b),
    .issueA_o       (issue_a),
    .issueB_o       (issue_b),
    .busyMask_o     (mask)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    en_a = 0; en_b = 0; pw_a = 0; pw_b = 0; pr_a = 0; pr_b = 0; sr_a = 0; sr_b = 0;
    prim_a = '0; prim_b = '0; sec_a = '0; sec_b = '0;
    wb_a = 0; wb_b = 0; wb_addr_a = '0; wb_addr_b = '0; flush = 0;
  endtask

  task automatic set_a(input logic en, input logic pw, input logic pr, input logic sr,
                       input logic [4:0] prim, input logic [4:0] sec);
    en_a = en; pw_a = pw; pr_a = pr; sr_a = sr; prim_a = prim; sec_a = sec;
  endtask

  task automatic set_b(input logic en, input logic pw, input logic pr, input logic sr,
                       input logic [4:0] prim, input logic [4:0] sec);
    en_b = en; pw_b = pw; pr_b = pr; sr_b = sr; prim_b = prim; sec_b = sec;
  endtask

  // Expected order of flags: {stallA, stallB, issueA, issueB}
  task automatic exp_flags(input string tag, input logic sa, input logic sb,
                           input logic ia, input logic ib);
    exp_t e;
    e.tag = tag; e.is_flags = 1'b1; e.sel = 32'hF; e.val = {28'h0, sa, sb, ia, ib};
    sb_q.push_back(e);
  endtask

  task automatic exp_mask(input string tag, input logic [31:0] sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.is_flags = 1'b0; e.sel = sel; e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic compare_now();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = e.is_flags ? {28'h0, stall_a, stall_b, issue_a, issue_b} : (mask & e.sel);
      total++;
      assert (obs === (e.val & e.sel)) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val & e.sel);
      end
    end
  endtask

  task automatic chk();
    @(negedge clk);
    compare_now();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    #2 reset_i = 1'b0;
    exp_mask("reset_mask", 32'hFFFF_FFFF, 32'h0);
    exp_flags("reset_flags", 0, 0, 0, 0);
    compare_now();
    #10 reset_i = 1'b1;
    tick();

    // Make r3 and r7 busy, then reset mid-run.
    set_a(1, 1, 0, 0, 5'd3, 5'd0);
    set_b(1, 1, 0, 0, 5'd7, 5'd0);
    exp_flags("busy37_issue", 0, 0, 1, 1);
    chk(); tick();
    idle();
    exp_mask("busy37_mask", 32'hFFFF_FFFF, 32'h0000_0088);
    chk();
    reset_i = 1'b0;
    #1;
    exp_mask("midrun_reset_mask", 32'hFFFF_FFFF, 32'h0);
    compare_now();
    #1 reset_i = 1'b1;
    tick();
    exp_flags("post_reset_idle", 0, 0, 0, 0);
    exp_mask("post_reset_mask", 32'hFFFF_FFFF, 32'h0);
    chk(); tick();

    // RAW on r5 cleared by writeback.
    set_a(1, 1, 0, 0, 5'd5, 5'd0);
    exp_flags("raw_issue_w5", 0, 0, 1, 0);
    chk(); tick();
    set_a(1, 0, 1, 0, 5'd5, 5'd0);
    set_b(1, 0, 1, 0, 5'd10, 5'd0);
    exp_flags("raw_stall_c1", 1, 1, 0, 0);
    exp_mask("raw_mask_c1", 32'hFFFF_FFFF, 32'h0000_0020);
    chk(); tick();
    wb_a = 1; wb_addr_a = 5'd5;
    exp_flags("raw_stall_wb_cycle", 1, 1, 0, 0);
    chk(); tick();
    wb_a = 0;
    exp_flags("raw_issue_c3", 0, 0, 1, 1);
    exp_mask("raw_mask_c3", 32'hFFFF_FFFF, 32'h0);
    chk(); tick();

    // Timeout on r9.
    idle();
    set_a(1, 1, 0, 0, 5'd9, 5'd0);
    exp_flags("tmo_issue_w9", 0, 0, 1, 0);
    chk(); tick();
    idle();
    for (int k = 1; k <= 6; k++) begin
      exp_mask($sformatf("tmo_busy_%0d", k), 32'h0000_0200, 32'h0000_0200);
      chk(); tick();
    end
    exp_mask("tmo_free_7", 32'hFFFF_FFFF, 32'h0);
    chk(); tick();

    // Intra-pair dependence.
    set_a(1, 1, 0, 0, 5'd4, 5'd0);
    set_b(1, 0, 1, 0, 5'd4, 5'd0);
    exp_flags("intra_dep_r4", 0, 1, 1, 0);
    chk(); tick();
    set_a(1, 1, 0, 0, 5'd12, 5'd0);
    set_b(1, 0, 1, 0, 5'd6, 5'd0);
    exp_flags("intra_nodep_r6", 0, 0, 1, 1);
    exp_mask("intra_mask", 32'hFFFF_FFFF, 32'h0000_0010);
    chk(); tick();

    // WAW on r2, then simultaneous load and writeback.
    idle();
    set_a(1, 1, 0, 0, 5'd2, 5'd0);
    exp_flags("waw_first_w2", 0, 0, 1, 0);
    exp_mask("waw_mask_pre", 32'hFFFF_FFFF, 32'h0000_1010);
    chk(); tick();
    exp_flags("waw_stall", 1, 0, 0, 0);
    exp_mask("waw_mask", 32'hFFFF_FFFF, 32'h0000_1014);
    chk(); tick();
    wb_b = 1; wb_addr_b = 5'd2;
    exp_flags("waw_stall_wb_cycle", 1, 0, 0, 0);
    chk(); tick();
    wb_b = 0;
    wb_a = 1; wb_addr_a = 5'd2;
    exp_flags("load_wb_issue", 0, 0, 1, 0);
    exp_mask("load_wb_r2_free", 32'h0000_0004, 32'h0);
    chk(); tick();
    idle();
    for (int k = 1; k <= 6; k++) begin
      exp_mask($sformatf("reload_busy_%0d", k), 32'h0000_0004, 32'h0000_0004);
      chk(); tick();
    end
    exp_mask("reload_free_7", 32'h0000_0004, 32'h0);
    chk(); tick();

    // Flush with r1, r2, r31 busy while A issues a write to r8.
    set_a(1, 1, 0, 0, 5'd1, 5'd0);
    set_b(1, 1, 0, 0, 5'd31, 5'd0);
    exp_flags("flush_prep_1_31", 0, 0, 1, 1);
    chk(); tick();
    idle();
    set_a(1, 1, 0, 0, 5'd2, 5'd0);
    exp_flags("flush_prep_2", 0, 0, 1, 0);
    chk(); tick();
    idle();
    flush = 1;
    set_a(1, 1, 0, 0, 5'd8, 5'd0);
    set_b(1, 0, 1, 0, 5'd1, 5'd0);
    exp_flags("flush_no_stall", 0, 0, 1, 1);
    exp_mask("flush_pre_mask", 32'h8000_0006, 32'h8000_0006);
    chk(); tick();
    idle();
    exp_mask("flush_post_mask", 32'hFFFF_FFFF, 32'h0);
    exp_flags("flush_post_idle", 0, 0, 0, 0);
    chk(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
